// File: rtl/i2c_bus_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_bus_arbiter_if
//  Purpose  : Bundles the request/grant handshake, per-master pad drives,
//             pad readback and muxed pad drive of the I2C bus arbiter.
//  Modports : slave  - the arbiter (takes requests, drives grant and pads)
//             master - the engines / top-level side (requests, pad readback)
//  Signals  : req, rel, gnt                      [N_REQ] handshake
//             m_scl_o, m_scl_t, m_sda_o, m_sda_t [N_REQ] per-master IOBUF I/T
//             scl_i, sda_i                              IOBUF O readback
//             scl_o, scl_t, sda_o, sda_t                muxed IOBUF I/T
//             busy, err_clr, timeout_err, err_owner[3]  status / error
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_bus_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] rel;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] m_scl_o;
    logic [N_REQ-1:0] m_scl_t;
    logic [N_REQ-1:0] m_sda_o;
    logic [N_REQ-1:0] m_sda_t;
    logic             scl_i;
    logic             sda_i;
    logic             scl_o;
    logic             scl_t;
    logic             sda_o;
    logic             sda_t;
    logic             busy;
    logic             err_clr;
    logic             timeout_err;
    logic [2:0]       err_owner;

    modport slave (
        input  req, rel, m_scl_o, m_scl_t, m_sda_o, m_sda_t,
        input  scl_i, sda_i, err_clr,
        output gnt, scl_o, scl_t, sda_o, sda_t, busy, timeout_err, err_owner
    );

    modport master (
        output req, rel, m_scl_o, m_scl_t, m_sda_o, m_sda_t,
        output scl_i, sda_i, err_clr,
        input  gnt, scl_o, scl_t, sda_o, sda_t, busy, timeout_err, err_owner
    );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_bus_arbiter
//  Purpose  : Shares one I2C SCL/SDA IOBUF pair between N_REQ master engines.
//             Round-robin grant, bus-free guard time before every grant and
//             a hold timeout that revokes a stuck owner (sticky error flag).
//  Ports    : clk    - system clock (clk_74_25 domain)
//             rst_n  - asynchronous active-low reset
//             bus    - i2c_bus_arbiter_if.slave (handshake, pad drives,
//                      pad readback, status)
//  Params   : N_REQ       2..8 requesters
//             IDLE_CYC    >=1 cycles of both lines high before a grant
//             TIMEOUT_CYC max grant hold in cycles, 0 disables
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter #(
    parameter int N_REQ       = 2,
    parameter int IDLE_CYC    = 370,
    parameter int TIMEOUT_CYC = 7425000
) (
    input  wire               clk,
    input  wire               rst_n,
    i2c_bus_arbiter_if.slave  bus
);

    localparam int          c_ptr_w    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          c_idle_w   = $clog2(IDLE_CYC + 1);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(IDLE_CYC);
    localparam logic [31:0] c_tmo_last = (TIMEOUT_CYC == 0) ? 32'd0
                                                            : 32'(TIMEOUT_CYC - 1);
    localparam logic [c_ptr_w-1:0]  c_last_idx = c_ptr_w'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_WAIT_IDLE = 1'b0,
        ST_GRANT     = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pad readback synchronizers; reset high so a freshly reset arbiter
    // sees an idle bus rather than a spurious low.
    // ------------------------------------------------------------------
    logic r_scl_meta, r_scl_sync;
    logic r_sda_meta, r_sda_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_scl_meta <= bus.scl_i;
            r_scl_sync <= r_scl_meta;
            r_sda_meta <= bus.sda_i;
            r_sda_sync <= r_sda_meta;
        end
    end

    logic w_lines_idle;
    assign w_lines_idle = r_scl_sync & r_sda_sync;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    state_t              r_state,    w_nxt_state;
    logic [N_REQ-1:0]    r_gnt,      w_nxt_gnt;
    logic [c_ptr_w-1:0]  r_owner,    w_nxt_owner;
    logic [c_ptr_w-1:0]  r_rr_ptr,   w_nxt_rr_ptr;
    logic [c_idle_w-1:0] r_idle_cnt, w_nxt_idle_cnt;
    logic [31:0]         r_tmo_cnt,  w_nxt_tmo_cnt;
    logic                r_busy,     w_nxt_busy;
    logic                r_scl_o,    w_nxt_scl_o;
    logic                r_scl_t,    w_nxt_scl_t;
    logic                r_sda_o,    w_nxt_sda_o;
    logic                r_sda_t,    w_nxt_sda_t;
    logic                r_err,      w_nxt_err;
    logic [2:0]          r_err_owner, w_nxt_err_owner;

    // Round-robin search: first asserted request starting at r_rr_ptr.
    logic               w_found;
    logic [c_ptr_w-1:0] w_winner;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && bus.req[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_found  = 1'b1;
                w_winner = c_ptr_w'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
    end

    // Owner gives up the bus by pulsing rel or dropping its request.
    logic w_release;
    logic w_tmo_hit;
    assign w_release = bus.rel[r_owner] | ~bus.req[r_owner];
    assign w_tmo_hit = (TIMEOUT_CYC != 0) && (r_tmo_cnt == c_tmo_last);

    logic [c_ptr_w-1:0] w_owner_next_ptr;
    assign w_owner_next_ptr = (r_owner == c_last_idx) ? '0
                                                      : r_owner + c_ptr_w'(1);

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_gnt       = r_gnt;
        w_nxt_owner     = r_owner;
        w_nxt_rr_ptr    = r_rr_ptr;
        w_nxt_idle_cnt  = r_idle_cnt;
        w_nxt_tmo_cnt   = r_tmo_cnt;
        w_nxt_busy      = r_busy;
        w_nxt_scl_o     = r_scl_o;
        w_nxt_scl_t     = r_scl_t;
        w_nxt_sda_o     = r_sda_o;
        w_nxt_sda_t     = r_sda_t;
        // Clear first so a timeout in the same cycle overrides it.
        w_nxt_err       = r_err & ~bus.err_clr;
        w_nxt_err_owner = r_err_owner;

        case (r_state)
            ST_WAIT_IDLE: begin
                if (!w_lines_idle) begin
                    w_nxt_idle_cnt = '0;
                end else if (r_idle_cnt != c_idle_max) begin
                    w_nxt_idle_cnt = r_idle_cnt + c_idle_w'(1);
                end

                if ((r_idle_cnt == c_idle_max) && w_found) begin
                    w_nxt_state         = ST_GRANT;
                    w_nxt_gnt           = '0;
                    w_nxt_gnt[w_winner] = 1'b1;
                    w_nxt_owner         = w_winner;
                    w_nxt_busy          = 1'b1;
                    w_nxt_tmo_cnt       = '0;
                end
            end

            ST_GRANT: begin
                if (w_release || w_tmo_hit) begin
                    w_nxt_state    = ST_WAIT_IDLE;
                    w_nxt_gnt      = '0;
                    w_nxt_busy     = 1'b0;
                    w_nxt_scl_o    = 1'b1;
                    w_nxt_scl_t    = 1'b1;
                    w_nxt_sda_o    = 1'b1;
                    w_nxt_sda_t    = 1'b1;
                    w_nxt_rr_ptr   = w_owner_next_ptr;
                    w_nxt_idle_cnt = '0;
                    // A release in the timeout cycle is a clean hand-back.
                    if (!w_release) begin
                        w_nxt_err       = 1'b1;
                        w_nxt_err_owner = 3'(r_owner);
                    end
                end else begin
                    w_nxt_tmo_cnt = r_tmo_cnt + 32'd1;
                    w_nxt_scl_o   = bus.m_scl_o[r_owner];
                    w_nxt_scl_t   = bus.m_scl_t[r_owner];
                    w_nxt_sda_o   = bus.m_sda_o[r_owner];
                    w_nxt_sda_t   = bus.m_sda_t[r_owner];
                end
            end

            default: begin
                w_nxt_state = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT_IDLE;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_idle_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_busy      <= 1'b0;
            r_scl_o     <= 1'b1;
            r_scl_t     <= 1'b1;
            r_sda_o     <= 1'b1;
            r_sda_t     <= 1'b1;
            r_err       <= 1'b0;
            r_err_owner <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_gnt       <= w_nxt_gnt;
            r_owner     <= w_nxt_owner;
            r_rr_ptr    <= w_nxt_rr_ptr;
            r_idle_cnt  <= w_nxt_idle_cnt;
            r_tmo_cnt   <= w_nxt_tmo_cnt;
            r_busy      <= w_nxt_busy;
            r_scl_o     <= w_nxt_scl_o;
            r_scl_t     <= w_nxt_scl_t;
            r_sda_o     <= w_nxt_sda_o;
            r_sda_t     <= w_nxt_sda_t;
            r_err       <= w_nxt_err;
            r_err_owner <= w_nxt_err_owner;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.busy        = r_busy;
    assign bus.scl_o       = r_scl_o;
    assign bus.scl_t       = r_scl_t;
    assign bus.sda_o       = r_sda_o;
    assign bus.sda_t       = r_sda_t;
    assign bus.timeout_err = r_err;
    assign bus.err_owner   = r_err_owner;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_bus_arbiter
//  Purpose  : Directed self-checking bench for i2c_bus_arbiter
//             (N_REQ=2, IDLE_CYC=4, TIMEOUT_CYC=100).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    i2c_bus_arbiter_if #(.N_REQ(2)) bus ();

    i2c_bus_arbiter #(
        .N_REQ       (2),
        .IDLE_CYC    (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for any grant; returns the number of edges waited.
    task automatic wait_gnt(output int n);
        n = 0;
        while (bus.gnt == 2'b00 && n < 40) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (bus.gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", bus.gnt); else n_pass++;
        n_checks++; if ({bus.scl_o, bus.scl_t, bus.sda_o, bus.sda_t} !== 4'b1111)
            $display("FAIL reset_pads: got %b want 1111", {bus.scl_o, bus.scl_t, bus.sda_o, bus.sda_t}); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.timeout_err); else n_pass++;
        n_checks++; if (bus.err_owner !== 3'd0) $display("FAIL reset_err_owner: got %0d want 0", bus.err_owner); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(8);
    endtask

    task automatic test_single();
        bus.m_scl_o = 2'b10;
        bus.m_scl_t = 2'b10;
        bus.req     = 2'b01;
        tick(1);
        n_checks++; if (bus.gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", bus.gnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else n_pass++;
        tick(1);
        n_checks++; if ({bus.scl_o, bus.scl_t} !== 2'b00)
            $display("FAIL single_scl_drive: got %b want 00", {bus.scl_o, bus.scl_t}); else n_pass++;
        bus.rel = 2'b01;
        tick(1);
        bus.rel = 2'b00;
        bus.req = 2'b00;
        n_checks++; if (bus.gnt !== 2'b00) $display("FAIL single_rel_gnt: got %b want 00", bus.gnt); else n_pass++;
        n_checks++; if ({bus.busy, bus.scl_o, bus.scl_t} !== 3'b011)
            $display("FAIL single_rel_pads: got busy/scl_o/scl_t %b want 011", {bus.busy, bus.scl_o, bus.scl_t}); else n_pass++;
        bus.m_scl_o = 2'b11;
        bus.m_scl_t = 2'b11;
    endtask

    // Previous owner was 0, so the rotation starts at master 1.
    task automatic test_contention();
        int n;
        logic [1:0] exp;
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b10 : 2'b01;
            wait_gnt(n);
            n_checks++; if (bus.gnt !== exp) $display("FAIL rr_gnt%0d: got %b want %b", k, bus.gnt, exp); else n_pass++;
            n_checks++; if (n !== 5) $display("FAIL rr_gap%0d: got %0d want 5", k, n); else n_pass++;
            if (k == 0) begin
                bus.rel = ~exp;
                tick(1);
                bus.rel = 2'b00;
                n_checks++; if (bus.gnt !== exp) $display("FAIL nonowner_rel: got %b want %b", bus.gnt, exp); else n_pass++;
            end
            tick(20);
            bus.rel = exp;
            tick(1);
            bus.rel = 2'b00;
            n_checks++; if (bus.gnt !== 2'b00) $display("FAIL rr_rel%0d: got %b want 00", k, bus.gnt); else n_pass++;
        end
        bus.req = 2'b00;
    endtask

    task automatic test_guard();
        int seen = 0;
        bus.sda_i = 1'b0;
        bus.req   = 2'b10;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (bus.gnt != 2'b00) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL guard_low_gnt: got %0d grant cycles want 0", seen); else n_pass++;
        bus.sda_i = 1'b1;
        tick(6);
        n_checks++; if (bus.gnt !== 2'b00) $display("FAIL guard_early: got %b want 00", bus.gnt); else n_pass++;
        tick(1);
        n_checks++; if (bus.gnt !== 2'b10) $display("FAIL guard_grant: got %b want 10", bus.gnt); else n_pass++;
        bus.rel = 2'b10;
        tick(1);
        bus.rel = 2'b00;
        bus.req = 2'b00;
        n_checks++; if (bus.gnt !== 2'b00) $display("FAIL guard_rel: got %b want 00", bus.gnt); else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        bus.req = 2'b10;
        wait_gnt(n);
        n_checks++; if (bus.gnt !== 2'b10) $display("FAIL tmo_gnt: got %b want 10", bus.gnt); else n_pass++;
        tick(99);
        n_checks++; if (bus.gnt !== 2'b10) $display("FAIL tmo_hold99: got %b want 10", bus.gnt); else n_pass++;
        tick(1);
        n_checks++; if ({bus.gnt, bus.busy} !== 3'b000) $display("FAIL tmo_drop: got gnt/busy %b want 000", {bus.gnt, bus.busy}); else n_pass++;
        n_checks++; if (bus.timeout_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", bus.timeout_err); else n_pass++;
        n_checks++; if (bus.err_owner !== 3'd1) $display("FAIL tmo_owner: got %0d want 1", bus.err_owner); else n_pass++;
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL clr_err: got %b want 0", bus.timeout_err); else n_pass++;
        n_checks++; if (bus.err_owner !== 3'd1) $display("FAIL clr_owner_kept: got %0d want 1", bus.err_owner); else n_pass++;
        wait_gnt(n);
        n_checks++; if (bus.gnt !== 2'b10) $display("FAIL tmo_regrant: got %b want 10", bus.gnt); else n_pass++;
        bus.req = 2'b00;
        tick(1);
        n_checks++; if ({bus.gnt, bus.timeout_err} !== 3'b000)
            $display("FAIL req_drop_release: got gnt/err %b want 000", {bus.gnt, bus.timeout_err}); else n_pass++;
    endtask

    task automatic test_rel_at_timeout();
        int n;
        bus.req = 2'b01;
        wait_gnt(n);
        n_checks++; if (bus.gnt !== 2'b01) $display("FAIL relt_gnt: got %b want 01", bus.gnt); else n_pass++;
        tick(99);
        bus.rel = 2'b01;
        tick(1);
        bus.rel = 2'b00;
        bus.req = 2'b00;
        n_checks++; if (bus.gnt !== 2'b00) $display("FAIL relt_drop: got %b want 00", bus.gnt); else n_pass++;
        n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL relt_no_err: got %b want 0", bus.timeout_err); else n_pass++;
    endtask

    task automatic test_clr_at_timeout();
        int n;
        bus.req = 2'b10;
        wait_gnt(n);
        n_checks++; if (bus.gnt !== 2'b10) $display("FAIL clrt_gnt1: got %b want 10", bus.gnt); else n_pass++;
        tick(100);
        n_checks++; if ({bus.timeout_err, bus.err_owner} !== 4'b1001)
            $display("FAIL clrt_first: got err/owner %b want 1001", {bus.timeout_err, bus.err_owner}); else n_pass++;
        bus.req = 2'b01;
        wait_gnt(n);
        n_checks++; if (bus.gnt !== 2'b01) $display("FAIL clrt_gnt0: got %b want 01", bus.gnt); else n_pass++;
        tick(99);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        n_checks++; if (bus.gnt !== 2'b00) $display("FAIL clrt_drop: got %b want 00", bus.gnt); else n_pass++;
        n_checks++; if ({bus.timeout_err, bus.err_owner} !== 4'b1000)
            $display("FAIL clrt_set_wins: got err/owner %b want 1000", {bus.timeout_err, bus.err_owner}); else n_pass++;
        bus.req     = 2'b00;
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        n_checks++; if ({bus.timeout_err, bus.err_owner} !== 4'b0000)
            $display("FAIL clrt_clear: got err/owner %b want 0000", {bus.timeout_err, bus.err_owner}); else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        int n;
        bus.m_scl_t = 2'b01;
        bus.m_sda_t = 2'b01;
        bus.req     = 2'b10;
        wait_gnt(n);
        n_checks++; if (bus.gnt !== 2'b10) $display("FAIL rstm_gnt: got %b want 10", bus.gnt); else n_pass++;
        tick(1);
        n_checks++; if ({bus.scl_t, bus.sda_t} !== 2'b00)
            $display("FAIL rstm_drive: got %b want 00", {bus.scl_t, bus.sda_t}); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.gnt, bus.busy, bus.scl_t, bus.sda_t} !== 5'b00011)
            $display("FAIL rstm_async: got gnt/busy/scl_t/sda_t %b want 00011",
                     {bus.gnt, bus.busy, bus.scl_t, bus.sda_t}); else n_pass++;
        bus.m_scl_t = 2'b11;
        bus.m_sda_t = 2'b11;
        bus.req     = 2'b11;
        tick(2);
        rst_n = 1'b1;
        wait_gnt(n);
        n_checks++; if (bus.gnt !== 2'b01) $display("FAIL rstm_first: got %b want 01", bus.gnt); else n_pass++;
        n_checks++; if (n !== 5) $display("FAIL rstm_latency: got %0d want 5", n); else n_pass++;
        bus.rel = 2'b01;
        tick(1);
        bus.rel = 2'b00;
        bus.req = 2'b00;
        n_checks++; if (bus.gnt !== 2'b00) $display("FAIL rstm_rel: got %b want 00", bus.gnt); else n_pass++;
    endtask

    initial begin
        bus.req     = 2'b00;
        bus.rel     = 2'b00;
        bus.m_scl_o = 2'b11;
        bus.m_scl_t = 2'b11;
        bus.m_sda_o = 2'b11;
        bus.m_sda_t = 2'b11;
        bus.scl_i   = 1'b1;
        bus.sda_i   = 1'b1;
        bus.err_clr = 1'b0;

        test_reset();
        test_single();
        test_contention();
        test_guard();
        test_timeout();
        test_rel_at_timeout();
        test_clr_at_timeout();
        test_reset_mid_grant();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
